// File: rtl/matrix_result_drain_if.sv
// Read-port and result-stream bundle for matrix_result_drain.
// The drain module uses the master side; memory and sink models use the slave side.
interface matrix_result_drain_if #(
  parameter int AW  = 8,
  parameter int ODW = 32
);
  logic           rd_en_o;
  logic [AW-1:0]  rd_addr_o;
  logic [ODW-1:0] rd_data_i;
  logic [ODW-1:0] m_data_o;
  logic           m_valid_o;
  logic           m_ready_i;
  logic           m_last_o;

  modport master (
    output rd_en_o, rd_addr_o, m_data_o, m_valid_o, m_last_o,
    input  rd_data_i, m_ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, m_data_o, m_valid_o, m_last_o,
    output rd_data_i, m_ready_i
  );
endinterface

// File: rtl/matrix_result_drain.sv
// Drains DIM_N*DIM_N result words in address order into a valid/ready stream with
// credit-limited read issue. Optional feature macro: RESULT_CHECKSUM_EN (adds checksum_o).
module matrix_result_drain #(
  parameter int DIM_N      = 4,
  parameter int AW         = 8,
  parameter int ODW        = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  matrix_result_drain_if.master bus
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [ODW-1:0] checksum_o
`endif
);
  localparam int NRES = DIM_N * DIM_N;
  localparam int CW   = AW + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int FW   = PW + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(NRES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  addr;
  logic [CW-1:0]  beat_cnt;
  logic [RD_LAT-1:0] rd_vld;
  logic [FW-1:0]  fifo_count;
  logic [FW-1:0]  inflight;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [ODW-1:0] fifo_mem [FIFO_DEPTH];
  logic           rd_en;
  logic           fifo_wr;
  logic           m_valid;
  logic           xfer;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + FW'(rd_vld[i]);
    end
  end

  // A read is only issued when the FIFO is guaranteed room for it on return.
  assign rd_en   = (state == ISSUE) && ((fifo_count + inflight) < FW'(FIFO_DEPTH));
  assign fifo_wr = rd_vld[RD_LAT-1];
  assign m_valid = (fifo_count != '0);
  assign xfer    = m_valid && bus.m_ready_i;

  assign bus.rd_en_o   = rd_en;
  assign bus.rd_addr_o = addr[AW-1:0];
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = m_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.m_last_o  = m_valid && (beat_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= ISSUE;
            addr   <= '0;
            busy_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_en) begin
            addr <= addr + CW'(1);
            if (addr == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && (beat_cnt == LAST_IDX)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      beat_cnt   <= '0;
    end else begin
      rd_vld[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (xfer) begin
        rd_ptr   <= rd_ptr + PW'(1);
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + CW'(1);
      end
      case ({fifo_wr, xfer})
        2'b10:   fifo_count <= fifo_count + FW'(1);
        2'b01:   fifo_count <= fifo_count - FW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= bus.rd_data_i;
  end

`ifdef RESULT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      checksum_o <= '0;
    end else if (xfer) begin
      checksum_o <= checksum_o + bus.m_data_o;
    end
  end
`endif
endmodule

// File: tb/tb_matrix_result_drain.sv
// Self-checking bench for matrix_result_drain: table-driven runs with random sink
// back-pressure against a queue-based reference, plus stall, restart and abort sequences.
module tb_matrix_result_drain;
  localparam int DIM_N      = 4;
  localparam int AW         = 8;
  localparam int ODW        = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NRES       = DIM_N * DIM_N;

  typedef struct {
    int             ready_pct;
    bit             spam;
    logic [ODW-1:0] base;
    int             exp_beats;
    logic [ODW-1:0] exp_sum;
  } vec_t;

  logic clk;
  logic rst;
  logic start_i;
  logic busy_o;
  logic done_o;
`ifdef RESULT_CHECKSUM_EN
  logic [ODW-1:0] checksum;
`endif

  matrix_result_drain_if #(.AW(AW), .ODW(ODW)) bus ();

  matrix_result_drain #(
    .DIM_N(DIM_N), .AW(AW), .ODW(ODW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .bus(bus)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum_o(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory with a fixed RD_LAT-cycle read pipeline.
  logic [ODW-1:0] mem  [1 << AW];
  logic [ODW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en_o ? mem[bus.rd_addr_o] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data_i = pipe[RD_LAT-1];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  bit mon_en = 1'b0;
  logic [ODW-1:0] exp_q [$];
  int reads_issued, outstanding, beats_seen, done_count;
  int first_valid_cycle, first_xfer_cycle, last_xfer_cycle, start_cycle;
  bit prev_stall;
  logic [ODW-1:0] prev_data;
  vec_t vecs [4];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic resetModel(input logic [ODW-1:0] base);
    exp_q.delete();
    for (int i = 0; i < NRES; i++) begin
      mem[i] = base + ODW'(i);
      exp_q.push_back(base + ODW'(i));
    end
    reads_issued = 0; outstanding = 0; beats_seen = 0; done_count = 0;
    first_valid_cycle = -1; first_xfer_cycle = -1; last_xfer_cycle = -1;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  // Outstanding = reads issued minus beats accepted; it may never exceed the buffer.
  task automatic sampleCycle();
    logic [ODW-1:0] want;
    if (bus.rd_en_o) begin
      checkOutput("credit", outstanding < FIFO_DEPTH, 1);
      checkOutput("rd_addr", bus.rd_addr_o, reads_issued);
      reads_issued++;
      outstanding++;
    end
    if (bus.m_valid_o) begin
      if (first_valid_cycle < 0) first_valid_cycle = cycle;
      checkOutput("m_last", bus.m_last_o, beats_seen == NRES - 1);
      if (prev_stall) checkOutput("hold_data", bus.m_data_o, prev_data);
    end else begin
      checkOutput("m_last_idle", bus.m_last_o, 0);
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_beat", 1, 0);
      end else begin
        want = exp_q.pop_front();
        checkOutput("m_data", bus.m_data_o, want);
      end
      if (first_xfer_cycle < 0) first_xfer_cycle = cycle;
      last_xfer_cycle = cycle;
      beats_seen++;
      outstanding--;
    end
    prev_stall = bus.m_valid_o && !bus.m_ready_i;
    prev_data  = bus.m_data_o;
    if (done_o) done_count++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle++;
    if (mon_en) sampleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkZeros(input string tag);
    @(negedge clk);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_rd_en"}, bus.rd_en_o, 0);
    checkOutput({tag, "_rd_addr"}, bus.rd_addr_o, 0);
    checkOutput({tag, "_m_valid"}, bus.m_valid_o, 0);
    checkOutput({tag, "_m_last"}, bus.m_last_o, 0);
    checkOutput({tag, "_m_data"}, bus.m_data_o, 0);
`ifdef RESULT_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, checksum, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    start_i = 1'b1;
    start_cycle = cycle + 1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int pct, input bit spam, input int budget);
    for (int k = 0; k < budget && done_count == 0; k++) begin
      start_i = spam && busy_o;
      bus.m_ready_i = (int'($urandom_range(99, 0)) < pct);
      tick();
    end
    start_i = 1'b0;
    checkOutput("done_seen", done_count != 0, 1);
  endtask

  task automatic runVector(input vec_t v);
    resetModel(v.base);
    mon_en = 1'b1;
    bus.m_ready_i = 1'b1;
    applyStimulus();
    waitDone(v.ready_pct, v.spam, 600);
    bus.m_ready_i = 1'b1;
    repeat (4) tick();
    checkOutput("beats", beats_seen, v.exp_beats);
    checkOutput("done_count", done_count, 1);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("reads", reads_issued, NRES);
    checkOutput("busy_after", busy_o, 0);
`ifdef RESULT_CHECKSUM_EN
    checkOutput("checksum", checksum, v.exp_sum);
`endif
    if (v.ready_pct >= 100) begin
      // Start is sampled one edge after it is driven; the first beat shows RD_LAT+1 edges later.
      checkOutput("first_valid_latency", first_valid_cycle - start_cycle, RD_LAT + 2);
      checkOutput("back_to_back", last_xfer_cycle - first_xfer_cycle, NRES - 1);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{100, 1'b0, 32'd1,          16, 32'd136};
    vecs[1] = '{50,  1'b0, 32'd1,          16, 32'd136};
    vecs[2] = '{40,  1'b1, 32'd100,        16, 32'd1720};
    vecs[3] = '{75,  1'b0, 32'hFFFF_FFF0,  16, 32'hFFFF_FF78};

    rst = 1'b1;
    start_i = 1'b0;
    bus.m_ready_i = 1'b1;
    resetModel(32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkZeros("reset");
    rst = 1'b0;
    repeat (20) checkZeros("idle");

    for (int v = 0; v < 4; v++) runVector(vecs[v]);

    // Sink stalled right from start: only the buffer's worth of reads may go out.
    resetModel(32'd1);
    mon_en = 1'b1;
    bus.m_ready_i = 1'b0;
    applyStimulus();
    repeat (30) tick();
    checkOutput("stall_reads", reads_issued, FIFO_DEPTH);
    checkOutput("stall_valid", bus.m_valid_o, 1);
    checkOutput("stall_data", bus.m_data_o, 1);
    waitDone(100, 1'b0, 600);
    repeat (4) tick();
    checkOutput("stall_beats", beats_seen, NRES);
    checkOutput("stall_done_count", done_count, 1);
    mon_en = 1'b0;

    // Start during the done cycle is ignored; the following cycle's start is taken.
    resetModel(32'd1);
    mon_en = 1'b1;
    bus.m_ready_i = 1'b1;
    applyStimulus();
    for (int k = 0; k < 200 && !done_o; k++) tick();
    checkOutput("done_pulse_seen", done_o, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    checkOutput("restart_ignored_busy", busy_o, 0);
    checkOutput("restart_ignored_reads", reads_issued, NRES);
    checkOutput("restart_done_count", done_count, 1);
    resetModel(32'd1);
    applyStimulus();
    checkOutput("restart_accept", busy_o, 1);
    waitDone(100, 1'b0, 600);
    repeat (4) tick();
    checkOutput("restart_beats", beats_seen, NRES);
    mon_en = 1'b0;

    // Abort after a few beats: everything clears and a fresh run is complete.
    resetModel(32'd1);
    mon_en = 1'b1;
    bus.m_ready_i = 1'b1;
    applyStimulus();
    for (int k = 0; k < 200 && beats_seen < 5; k++) tick();
    checkOutput("abort_reached", beats_seen >= 5, 1);
    rst = 1'b1;
    tick();
    mon_en = 1'b0;
    checkZeros("abort");
    rst = 1'b0;
    repeat (6) checkZeros("post_abort");
    runVector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
